tawas_dbus_arb: RTL
===================

Name: tawas_dbus_arb

Overview:
Data-bus arbiter between the tawas core load/store port and the data SRAM.
- The core port has absolute priority and passes through combinationally, so core load latency is unchanged.
- Two auxiliary masters (A0, A1, e.g. DMA and debug) use a req/ack handshake and share the idle bus cycles round-robin.
- Read data returns on the cycle after the address, tagged to its owner.

Parameters:
STARVE_LIMIT, 64, consecutive un-acked request cycles before Ax_STARVE asserts (used only with the optional feature; range 1..255).

Ports:
CLK  input  1  clock
RST  input  1  reset, asynchronous, active-high
C_DADDR  input  32  core address
C_DCS  input  1  core access strobe
C_DWR  input  1  core write (1) / read (0)
C_DMASK  input  4  core byte mask
C_DOUT  input  32  core write data
C_DIN  output  32  core read data
A0_REQ  input  1  aux0 request, held until ack
A0_WR  input  1  aux0 write (1) / read (0)
A0_ADDR  input  32  aux0 address
A0_MASK  input  4  aux0 byte mask
A0_WDATA  input  32  aux0 write data
A0_ACK  output  1  aux0 grant, one cycle per access
A0_RDATA  output  32  aux0 read data
A0_RVLD  output  1  aux0 read data valid
A0_STARVE  output  1  aux0 starvation flag
A1_*  same set as A0_*  aux1 equivalents
M_DADDR  output  32  SRAM address
M_DCS  output  1  SRAM strobe
M_DWR  output  1  SRAM write
M_DMASK  output  4  SRAM byte mask
M_DOUT  output  32  SRAM write data
M_DIN  input  32  SRAM read data, valid the cycle after M_DCS

Behaviour:
- Reset values: rr_ptr=0 (A0 preferred next), owner_q=NONE, rd_q=0, all ACK/RVLD/STARVE=0, starve counters=0.
- Reset is asynchronous; a read in flight at reset is dropped and no RVLD is issued.
- Arbitration is combinational each cycle:
  - C_DCS=1: core owns the bus. M_* = C_* and no ACK.
  - C_DCS=0, exactly one Ax_REQ: grant Ax, drive M_* from Ax (M_DCS=1), Ax_ACK=1.
  - C_DCS=0, both REQ: grant the master selected by rr_ptr.
  - No requests: M_DCS=0; M_DADDR/M_DMASK/M_DOUT/M_DWR hold core values (don't-care).
- rr_ptr update, only on an aux grant: rr_ptr <= index of the master not granted. Core cycles and idle cycles leave it unchanged.
- Handshake:
  - Requester holds REQ and all fields stable until it samples ACK=1.
  - It may deassert REQ next cycle or present a new access; back-to-back grants to one master are allowed when the other is idle.
  - Dropping REQ before ACK aborts the request with no side effect.
- Read return:
  - Register owner_q and rd_q (= granted & ~WR) at each edge.
  - C_DIN = M_DIN always.
  - Ax_RDATA = M_DIN always; Ax_RVLD = rd_q && owner_q==Ax.
  - Exactly one cycle after ACK of a read; writes give no RVLD.
- Simultaneous core access and aux read return in the same cycle is legal: the SRAM is pipelined, one address per cycle.
- Latency: core 0 extra cycles; aux grant same cycle as REQ when the bus is free; aux read data at ACK+1.
- Aux wait is unbounded while the core issues every cycle; the arbiter never stalls the core.

Optional Feature:
Macro TAWAS_DBUS_ARB_STARVE_EN.
- Defined:
  - Per-aux 8-bit saturating counter: increments each cycle Ax_REQ & ~Ax_ACK; clears on ACK or when REQ=0.
  - Ax_STARVE = (count >= STARVE_LIMIT), registered, so it asserts the cycle after the count reaches the limit.
- Undefined: no counters; Ax_STARVE tied 0. The port list is identical either way.

Test Plan:
- Reset with A0_REQ=1 and C_DCS=0 → M_DCS=0, ACK=0 while RST=1; first cycle after release → A0_ACK=1, M_DADDR=A0_ADDR.
- Core read 0x100 concurrent with A0_REQ read 0x200 → cycle N: M_DADDR=0x100, A0_ACK=0. Cycle N+1, core idle: A0_ACK=1, M_DADDR=0x200. Cycle N+2: A0_RVLD=1, A0_RDATA=M_DIN.
- A0 and A1 requesting continuously, core idle → grants alternate A0,A1,A0,A1 from reset; RVLD appears one cycle after each read ACK to the correct master only.
- A1 write 0xDEADBEEF, mask 0x3, addr 0x40 → M_DWR=1, M_DMASK=0x3, M_DOUT=0xDEADBEEF for one cycle; no A1_RVLD follows.
- A0 read acked, RST pulsed the next cycle → A0_RVLD stays 0; after release rr_ptr=0 and owner_q=NONE.
- STARVE_EN defined, STARVE_LIMIT=4, C_DCS=1 for 10 cycles with A0_REQ=1 → A0_STARVE rises after the 4th un-acked cycle and clears the cycle after A0_ACK. Macro undefined → A0_STARVE stays 0.

Source files
------------

// File: rtl/tawas_dbus_arb.sv
// tawas_dbus_arb: data-bus arbiter, core passthrough with priority, two round-robin aux masters.
// Optional starvation flags enabled by TAWAS_DBUS_ARB_STARVE_EN.
module tawas_dbus_arb #(
    parameter int STARVE_LIMIT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] C_DADDR,
    input  logic        C_DCS,
    input  logic        C_DWR,
    input  logic [3:0]  C_DMASK,
    input  logic [31:0] C_DOUT,
    output logic [31:0] C_DIN,
    input  logic        A0_REQ,
    input  logic        A0_WR,
    input  logic [31:0] A0_ADDR,
    input  logic [3:0]  A0_MASK,
    input  logic [31:0] A0_WDATA,
    output logic        A0_ACK,
    output logic [31:0] A0_RDATA,
    output logic        A0_RVLD,
    output logic        A0_STARVE,
    input  logic        A1_REQ,
    input  logic        A1_WR,
    input  logic [31:0] A1_ADDR,
    input  logic [3:0]  A1_MASK,
    input  logic [31:0] A1_WDATA,
    output logic        A1_ACK,
    output logic [31:0] A1_RDATA,
    output logic        A1_RVLD,
    output logic        A1_STARVE,
    output logic [31:0] M_DADDR,
    output logic        M_DCS,
    output logic        M_DWR,
    output logic [3:0]  M_DMASK,
    output logic [31:0] M_DOUT,
    input  logic [31:0] M_DIN
);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CORE = 2'd1;
    localparam logic [1:0] OWN_A0   = 2'd2;
    localparam logic [1:0] OWN_A1   = 2'd3;

    logic       rr_ptr_q, rr_ptr_d, rd_q, rd_d, gnt0, gnt1;
    logic [1:0] owner_q, owner_d;

    always_comb begin
        gnt0     = ~RST & ~C_DCS & A0_REQ & (~A1_REQ | ~rr_ptr_q);
        gnt1     = ~RST & ~C_DCS & A1_REQ & ~gnt0;
        M_DCS    = C_DCS | gnt0 | gnt1;
        M_DADDR  = gnt0 ? A0_ADDR  : gnt1 ? A1_ADDR  : C_DADDR;
        M_DWR    = gnt0 ? A0_WR    : gnt1 ? A1_WR    : C_DWR;
        M_DMASK  = gnt0 ? A0_MASK  : gnt1 ? A1_MASK  : C_DMASK;
        M_DOUT   = gnt0 ? A0_WDATA : gnt1 ? A1_WDATA : C_DOUT;
        A0_ACK   = gnt0;
        A1_ACK   = gnt1;
        rr_ptr_d = gnt0 ? 1'b1 : gnt1 ? 1'b0 : rr_ptr_q;
        owner_d  = gnt0 ? OWN_A0 : gnt1 ? OWN_A1 : C_DCS ? OWN_CORE : OWN_NONE;
        rd_d     = M_DCS & ~M_DWR;
        C_DIN    = M_DIN;
        A0_RDATA = M_DIN;
        A1_RDATA = M_DIN;
        A0_RVLD  = rd_q & (owner_q == OWN_A0);
        A1_RVLD  = rd_q & (owner_q == OWN_A1);
    end

    // Reset drops any read in flight: owner_q returns to NONE so no RVLD follows.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr_q <= 1'b0;
            owner_q  <= OWN_NONE;
            rd_q     <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            rd_q     <= rd_d;
        end
    end

`ifdef TAWAS_DBUS_ARB_STARVE_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [1:0][7:0] cnt_q, cnt_d;
    logic [1:0]      starve_q, starve_d, req, ack;

    always_comb begin
        req = {A1_REQ, A0_REQ};
        ack = {A1_ACK, A0_ACK};
        for (int i = 0; i < 2; i++) begin
            cnt_d[i]    = (req[i] & ~ack[i]) ? ((cnt_q[i] == 8'hFF) ? cnt_q[i] : cnt_q[i] + 8'd1) : 8'd0;
            starve_d[i] = cnt_d[i] >= LIMIT;
        end
        A0_STARVE = starve_q[0];
        A1_STARVE = starve_q[1];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end
`else
    logic unused_limit;

    assign unused_limit = ^STARVE_LIMIT;
    assign A0_STARVE    = 1'b0;
    assign A1_STARVE    = 1'b0;
`endif

endmodule
